// File: rtl/program_loader_if.sv
// Byte-stream input and CPU program-download outputs of the program loader.
// slave: the loader itself; master: whatever feeds bytes and observes the CPU side.
interface program_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        download_program;
    logic [31:0] instruction_index;
    logic [15:0] program_in;
    logic        prog_we;
    logic        busy;
    logic        done;
    logic        error;

    modport slave (
        input  rx_valid, rx_data,
        output download_program, instruction_index, program_in, prog_we, busy, done, error
    );

    modport master (
        output rx_valid, rx_data,
        input  download_program, instruction_index, program_in, prog_we, busy, done, error
    );
endinterface

// File: rtl/program_loader.sv
// Parses SYNC/LEN/DATA/CHK frames from a byte stream and writes Thumb halfwords to the CPU.
// Latency: prog_we one cycle after DATA_HI is accepted. No backpressure: rx_valid bytes are consumed every cycle.
// Optional inter-byte timeout when LOADER_TIMEOUT_EN is defined.
module program_loader #(
    parameter logic [31:0] BASE_INDEX     = 32'd0,
    parameter int unsigned MAX_WORDS      = 256,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    program_loader_if.slave  lif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t      state, nxt_state;
    logic [7:0]  len_lo, data_lo, xor_acc;
    logic [15:0] len, word_cnt, len_full;
    logic [31:0] index_r;
    logic [15:0] prog_r;
    logic        we_r;
    logic        busy_s;
    logic        tmo_hit;
    logic        is_sync;

    assign len_full = {lif.rx_data, len_lo};
    assign is_sync  = (lif.rx_data == SYNC_BYTE);
    assign busy_s   = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA_LO) ||
                      (state == S_DATA_HI) || (state == S_CHECK);

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (!busy_s || lif.rx_valid)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 32'd1;
    end

    assign tmo_hit = busy_s && !lif.rx_valid && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout a stalled frame simply waits for more bytes.
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        if (tmo_hit) begin
            nxt_state = S_ERROR;
        end else if (state == S_DONE) begin
            nxt_state = S_IDLE;
        end else if (lif.rx_valid) begin
            case (state)
                S_IDLE:    if (is_sync) nxt_state = S_LEN_LO;
                S_LEN_LO:  nxt_state = S_LEN_HI;
                S_LEN_HI: begin
                    if ({16'd0, len_full} > 32'(MAX_WORDS))
                        nxt_state = S_ERROR;
                    else if (len_full == 16'd0)
                        nxt_state = S_CHECK;
                    else
                        nxt_state = S_DATA_LO;
                end
                S_DATA_LO: nxt_state = S_DATA_HI;
                S_DATA_HI: nxt_state = (16'(word_cnt + 16'd1) == len) ? S_CHECK : S_DATA_LO;
                S_CHECK:   nxt_state = (lif.rx_data == xor_acc) ? S_DONE : S_ERROR;
                S_ERROR:   if (is_sync) nxt_state = S_LEN_LO;
                default:   nxt_state = S_IDLE;
            endcase
        end
    end

    // Datapath: the write strobe is registered so the halfword lands one cycle after its high byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo   <= '0;
            data_lo  <= '0;
            xor_acc  <= '0;
            len      <= '0;
            word_cnt <= '0;
            index_r  <= '0;
            prog_r   <= '0;
            we_r     <= 1'b0;
        end else begin
            we_r <= 1'b0;
            if (lif.rx_valid) begin
                case (state)
                    S_IDLE, S_ERROR: begin
                        if (is_sync) begin
                            xor_acc  <= '0;
                            word_cnt <= '0;
                        end
                    end
                    S_LEN_LO: begin
                        len_lo  <= lif.rx_data;
                        xor_acc <= xor_acc ^ lif.rx_data;
                    end
                    S_LEN_HI: begin
                        len     <= len_full;
                        xor_acc <= xor_acc ^ lif.rx_data;
                    end
                    S_DATA_LO: begin
                        data_lo <= lif.rx_data;
                        xor_acc <= xor_acc ^ lif.rx_data;
                    end
                    S_DATA_HI: begin
                        xor_acc  <= xor_acc ^ lif.rx_data;
                        prog_r   <= {lif.rx_data, data_lo};
                        index_r  <= BASE_INDEX + {16'd0, word_cnt};
                        word_cnt <= word_cnt + 16'd1;
                        we_r     <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ERROR keeps download_program high so the CPU stays halted on a bad image.
    always_comb begin
        lif.download_program  = busy_s || (state == S_ERROR);
        lif.busy              = busy_s;
        lif.done              = (state == S_DONE);
        lif.error             = (state == S_ERROR);
        lif.prog_we           = we_r;
        lif.instruction_index = index_r;
        lif.program_in        = prog_r;
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized frame stimulus for program_loader checked against a frame-level reference model.
module tb_program_loader;

    localparam logic [31:0] BASE = 32'd10;
    localparam int          MAXW = 256;

    logic clk;
    logic rst_n;

    program_loader_if lif ();

    program_loader #(
        .BASE_INDEX    (BASE),
        .MAX_WORDS     (MAXW),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .lif  (lif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  frame_q[$];
    logic [15:0] exp_words[$];
    logic [31:0] wr_idx_q[$];
    logic [15:0] wr_dat_q[$];
    int          done_cnt = 0;
    logic [31:0] last_idx;
    logic [15:0] last_dat;

    always @(negedge clk) begin
        if (rst_n && lif.prog_we) begin
            wr_idx_q.push_back(lif.instruction_index);
            wr_dat_q.push_back(lif.program_in);
        end
        if (lif.done) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: a frame is SYNC, LEN (LE), LEN halfwords (LE), XOR of everything after SYNC.
    task automatic build_frame(input int len, input bit bad);
        logic [7:0]  chk;
        logic [15:0] w;
        frame_q.delete();
        exp_words.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(len[7:0]);
        frame_q.push_back(len[15:8]);
        if (len <= MAXW) begin
            for (int i = 0; i < len; i++) begin
                w = 16'($urandom);
                exp_words.push_back(w);
                frame_q.push_back(w[7:0]);
                frame_q.push_back(w[15:8]);
            end
            chk = 8'h00;
            for (int i = 1; i < frame_q.size(); i++) chk = chk ^ frame_q[i];
            if (bad) chk = chk ^ 8'($urandom_range(1, 255));
            frame_q.push_back(chk);
        end
    endtask

    task automatic send_bytes(input int first, input int last_excl, input int max_gap);
        int gap;
        for (int i = first; i < last_excl; i++) begin
            lif.rx_valid = 1'b1;
            lif.rx_data  = frame_q[i];
            @(negedge clk);
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            if (gap > 0) begin
                lif.rx_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        lif.rx_valid = 1'b0;
    endtask

    task automatic check_frame(input string name, input int wr_base, input int done_base,
                               input bit exp_ok);
        int n;
        repeat (3) @(negedge clk);
        n = wr_idx_q.size() - wr_base;
        n_checks++;
        if (n !== exp_words.size()) begin
            n_fail++;
            $display("FAIL %s write_count got %0d expected %0d", name, n, exp_words.size());
        end else begin
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (wr_idx_q[wr_base+i] !== BASE + 32'(i) || wr_dat_q[wr_base+i] !== exp_words[i]) begin
                    n_fail++;
                    $display("FAIL %s write[%0d] got idx %0d data %h expected idx %0d data %h", name, i,
                             wr_idx_q[wr_base+i], wr_dat_q[wr_base+i], BASE + 32'(i), exp_words[i]);
                end
            end
        end
        if (exp_words.size() > 0) begin
            last_idx = BASE + 32'(exp_words.size() - 1);
            last_dat = exp_words[exp_words.size()-1];
        end
        n_checks++;
        if ((done_cnt - done_base) !== (exp_ok ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s done_pulses got %0d expected %0d", name, done_cnt - done_base, exp_ok ? 1 : 0);
        end
        n_checks++;
        if (lif.error !== !exp_ok || lif.download_program !== !exp_ok || lif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s flags got err=%b dl=%b busy=%b expected err=%b dl=%b busy=0", name,
                     lif.error, lif.download_program, lif.busy, !exp_ok, !exp_ok);
        end
        n_checks++;
        if (lif.instruction_index !== last_idx || lif.program_in !== last_dat) begin
            n_fail++;
            $display("FAIL %s hold got idx %0d data %h expected idx %0d data %h", name,
                     lif.instruction_index, lif.program_in, last_idx, last_dat);
        end
    endtask

    task automatic run_frame(input string name, input int len, input bit bad, input int max_gap);
        int wb, db;
        wb = wr_idx_q.size();
        db = done_cnt;
        build_frame(len, bad);
        send_bytes(0, frame_q.size(), max_gap);
        check_frame(name, wb, db, !bad && len <= MAXW);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({lif.download_program, lif.prog_we, lif.busy, lif.done, lif.error} !== 5'b0 ||
            lif.instruction_index !== 32'd0 || lif.program_in !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got dl=%b we=%b busy=%b done=%b err=%b idx=%0d data=%h expected all 0",
                     lif.download_program, lif.prog_we, lif.busy, lif.done, lif.error,
                     lif.instruction_index, lif.program_in);
        end
    endtask

    task automatic test_nominal();
        int wb, db;
        wb = wr_idx_q.size();
        db = done_cnt;
        frame_q   = '{8'hA5, 8'h02, 8'h00, 8'h05, 8'h20, 8'hC2, 8'h1F, 8'hFA};
        exp_words = '{16'h2005, 16'h1FC2};
        send_bytes(0, 1, 0);
        n_checks++;
        if (lif.download_program !== 1'b1 || lif.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_after_sync got dl=%b busy=%b expected 1 1", lif.download_program, lif.busy);
        end
        send_bytes(1, frame_q.size(), 0);
        check_frame("nominal", wb, db, 1'b1);
    endtask

    task automatic test_bad_checksum();
        int wb, db;
        wb = wr_idx_q.size();
        db = done_cnt;
        frame_q   = '{8'hA5, 8'h02, 8'h00, 8'h05, 8'h20, 8'hC2, 8'h1F, 8'hFB};
        exp_words = '{16'h2005, 16'h1FC2};
        send_bytes(0, frame_q.size(), 0);
        check_frame("bad_checksum", wb, db, 1'b0);
    endtask

    task automatic test_oversize();
        int wb, db;
        wb = wr_idx_q.size();
        db = done_cnt;
        frame_q = '{8'hA5, 8'h01, 8'h01};
        exp_words.delete();
        send_bytes(0, 3, 0);
        n_checks++;
        if (lif.error !== 1'b1) begin
            n_fail++;
            $display("FAIL oversize_immediate error got %b expected 1", lif.error);
        end
        check_frame("oversize", wb, db, 1'b0);
        run_frame("after_oversize", 3, 1'b0, 0);
    endtask

    task automatic test_zero_len();
        int wb, db;
        wb = wr_idx_q.size();
        db = done_cnt;
        frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        exp_words.delete();
        send_bytes(0, 4, 0);
        check_frame("zero_len", wb, db, 1'b1);
    endtask

    task automatic test_max_len();
        run_frame("max_len", MAXW, 1'b0, 0);
    endtask

    task automatic test_reset_midframe();
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h05, 8'h20, 8'hC2, 8'h1F, 8'hFA};
        send_bytes(0, 4, 0);
        #1 rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst_n    = 1'b1;
        last_idx = 32'd0;
        last_dat = 16'd0;
        @(negedge clk);
        test_nominal();
    endtask

    task automatic test_stall();
        build_frame(2, 1'b0);
        send_bytes(0, 3, 0);
`ifdef LOADER_TIMEOUT_EN
        repeat (45) @(negedge clk);
        n_checks++;
        if (lif.error !== 1'b0 || lif.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_early got err=%b busy=%b expected 0 1", lif.error, lif.busy);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (lif.error !== 1'b1 || lif.download_program !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_timeout got err=%b dl=%b expected 1 1", lif.error, lif.download_program);
        end
        run_frame("after_timeout", 2, 1'b0, 0);
`else
        repeat (60) @(negedge clk);
        n_checks++;
        if (lif.error !== 1'b0 || lif.busy !== 1'b1 || lif.download_program !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_wait got err=%b busy=%b dl=%b expected 0 1 1",
                     lif.error, lif.busy, lif.download_program);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        last_idx = 32'd0;
        last_dat = 16'd0;
        @(negedge clk);
        run_frame("after_stall_reset", 2, 1'b0, 0);
`endif
    endtask

    task automatic test_random(input int n_frames, input int max_gap);
        int len, r;
        bit bad;
        for (int f = 0; f < n_frames; f++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      len = (f % 2 == 0) ? 65535 : 257 + $urandom_range(0, 1000);
            else if (r == 1) len = 0;
            else             len = $urandom_range(1, 8);
            bad = ($urandom_range(0, 3) == 0);
            run_frame($sformatf("random_%0d_gap%0d", f, max_gap), len, bad, max_gap);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        lif.rx_valid = 1'b0;
        lif.rx_data  = 8'h00;
        last_idx     = 32'd0;
        last_dat     = 16'd0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_oversize();
        test_zero_len();
        test_max_len();
        test_reset_midframe();
        test_stall();
        test_random(20, 0);
        test_random(20, 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
